// File: rtl/stream_mux_pkg.sv
// Shared mode encoding and flattened-bus helpers for the stream multiplexer.
package mux_pkg;

  typedef logic mux_mode_t;

  localparam mux_mode_t MODE_FIXED = 1'b0;
  localparam mux_mode_t MODE_RR    = 1'b1;

  // LSB position of channel idx inside a flattened bus of width-wide channels.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority encoder: first asserted req at or above ptr, wrapping at N-1.
// Purely combinational; grant_valid low when no request is present.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW-1:0] w_idx;

  // Scan from the farthest candidate down so the nearest one to ptr wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = SW'((int'(ptr) + k) % N);
      if (req[w_idx]) begin
        grant       = w_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// Registered N-to-1 valid/ready mux (fixed select or round-robin), 1-cycle latency.
// Single output stage drains and refills in the same cycle; in_ready all low on stall.
module stream_mux
  import mux_pkg::*;
#(
  parameter int NUM_IN    = 16,
  parameter int IN_WIDTH  = 32,
  parameter int SEL_WIDTH = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*IN_WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  mux_mode_t                    mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [IN_WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [IN_WIDTH-1:0]  r_out_data;
  logic [SEL_WIDTH-1:0] r_out_sel;
  logic                 r_out_valid;
  logic [SEL_WIDTH-1:0] r_ptr;

  logic [IN_WIDTH-1:0]  w_chan [NUM_IN];
  logic [SEL_WIDTH-1:0] w_rr_grant;
  logic                 w_rr_grant_vld;
  logic                 w_sel_in_range;
  logic                 w_fixed_grant_vld;
  logic [SEL_WIDTH-1:0] w_grant;
  logic                 w_grant_vld;
  logic                 w_can_accept;
  logic                 w_xfer;
  logic [IN_WIDTH-1:0]  w_grant_data;
  logic [SEL_WIDTH-1:0] w_ptr_next;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    assign w_chan[i] = in_data[slice_lsb(i, IN_WIDTH) +: IN_WIDTH];
  end

  // Only a non-power-of-two channel count leaves sel codes without a channel.
  if ((1 << SEL_WIDTH) == NUM_IN) begin : g_pow2
    assign w_sel_in_range = 1'b1;
  end else begin : g_npow2
    assign w_sel_in_range = (int'(sel) < NUM_IN);
  end

  rr_arbiter #(
    .N  (NUM_IN),
    .SW (SEL_WIDTH)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_grant_vld)
  );

  assign w_fixed_grant_vld = w_sel_in_range && in_valid[sel];
  assign w_grant           = (mode == MODE_RR) ? w_rr_grant : sel;
  assign w_grant_vld       = (mode == MODE_RR) ? w_rr_grant_vld : w_fixed_grant_vld;
  assign w_can_accept      = !r_out_valid || out_ready;
  assign w_xfer            = w_can_accept && w_grant_vld && !rst;
  assign w_grant_data      = w_chan[w_grant];
  assign w_ptr_next        = (w_grant == SEL_WIDTH'(NUM_IN - 1)) ? '0
                                                                 : w_grant + SEL_WIDTH'(1);

  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_sel   <= w_grant;
        if (mode == MODE_RR) begin
          r_ptr <= w_ptr_next;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: driver pushes model-predicted words, negedge monitor pops/compares.
module tb_stream_mux;
  import mux_pkg::*;

  localparam int NUM_IN = 16;
  localparam int IN_W   = 32;
  localparam int SEL_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_IN*IN_W-1:0]   in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [IN_W-1:0]          out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_valid;
  logic                     out_ready;

  stream_mux #(.NUM_IN(NUM_IN), .IN_WIDTH(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [IN_W-1:0]   dat [NUM_IN];
  int                m_ptr;
  bit                m_occ;
  logic [IN_W-1:0]   q_d [$];
  int                q_s [$];
  logic [NUM_IN-1:0] exp_in_ready;
  bit                exp_out_valid;
  bit                chk_en;
  int                n_chk;
  int                n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic pack_data();
    for (int i = 0; i < NUM_IN; i++) in_data[i*IN_W +: IN_W] = dat[i];
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NUM_IN; i++) dat[i] = IN_W'(1000 * i);
  endtask

  // Grant rule: fixed = sel if requesting; round-robin = first requester from ptr upward, wrapping.
  function automatic void model_grant(input logic [NUM_IN-1:0] v, input logic md, input int s,
                                      output bit found, output int g);
    found = 0;
    g     = 0;
    if (md == MODE_FIXED) begin
      if (s < NUM_IN && v[s]) begin
        found = 1;
        g     = s;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        int c;
        c = (m_ptr + k) % NUM_IN;
        if (!found && v[c]) begin
          found = 1;
          g     = c;
        end
      end
    end
  endfunction

  // Called at posedge+1: applies inputs for the coming edge and predicts its effect.
  task automatic step(input logic [NUM_IN-1:0] v, input logic md, input int s, input logic ordy);
    bit found;
    int g;
    in_valid  = v;
    mode      = md;
    sel       = s[SEL_W-1:0];
    out_ready = ordy;
    pack_data();
    exp_out_valid = m_occ;
    exp_in_ready  = '0;
    model_grant(v, md, s, found, g);
    if ((!m_occ || ordy) && found) begin
      exp_in_ready[g] = 1'b1;
      q_d.push_back(dat[g]);
      q_s.push_back(g);
      if (md == MODE_RR) m_ptr = (g + 1) % NUM_IN;
      m_occ = 1;
    end else if (ordy) begin
      m_occ = 0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
      chk("out_valid", 64'(out_valid), 64'(exp_out_valid));
      if (out_valid) begin
        if (q_d.size() == 0) begin
          chk("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          chk("out_data", 64'(out_data), 64'(q_d[0]));
          chk("out_sel", 64'(out_sel), 64'(q_s[0]));
          if (out_ready) begin
            void'(q_d.pop_front());
            void'(q_s.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; chk_en = 0;
    m_ptr = 0; m_occ = 0;
    exp_in_ready = '0; exp_out_valid = 0;
    set_ramp();
    pack_data();
    rst = 1'b1; in_valid = '1; mode = MODE_RR; sel = '0; out_ready = 1'b1;

    // Reset state, with all channels requesting
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;

    // Fixed-mode sweep
    for (int s = 0; s < NUM_IN; s++) step('1, MODE_FIXED, s, 1'b1);
    step('0, MODE_FIXED, 0, 1'b1);

    // Round-robin fairness: 0..15 twice
    for (int i = 0; i < 2 * NUM_IN; i++) step('1, MODE_RR, 0, 1'b1);

    // Sparse requests on 3 and 14, then only 14 to force the pointer wrap
    for (int i = 0; i < 4; i++) step(16'h4008, MODE_RR, 0, 1'b1);
    for (int i = 0; i < 2; i++) step(16'h4000, MODE_RR, 0, 1'b1);
    step('0, MODE_RR, 0, 1'b1);

    // Backpressure: word 2000 held while sel moves to 9
    step('1, MODE_FIXED, 2, 1'b1);
    for (int i = 0; i < 5; i++) step('1, MODE_FIXED, (i < 2) ? 2 : 9, 1'b0);
    step('1, MODE_FIXED, 9, 1'b1);
    step('0, MODE_FIXED, 9, 1'b1);
    step('0, MODE_FIXED, 9, 1'b1);

    // Fixed select on an idle channel
    step('1, MODE_FIXED, 1, 1'b1);
    for (int i = 0; i < 3; i++) step(16'hFFDF, MODE_FIXED, 5, 1'b1);

    // Randomized traffic with changing data
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_IN; i++) dat[i] = $urandom;
      step(NUM_IN'($urandom), logic'($urandom_range(0, 1)), $urandom_range(0, NUM_IN - 1),
           logic'($urandom_range(0, 3) != 0));
    end
    step('0, MODE_FIXED, 0, 1'b1);
    step('0, MODE_FIXED, 0, 1'b1);

    // Async reset while a word is held; the word must be discarded
    set_ramp();
    step('1, MODE_FIXED, 7, 1'b1);
    step('1, MODE_FIXED, 7, 1'b0);
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_sel", 64'(out_sel), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    q_d.delete(); q_s.delete();
    m_occ = 0; m_ptr = 0;
    exp_in_ready = '0; exp_out_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step('1, MODE_RR, 0, 1'b1);
    step('0, MODE_RR, 0, 1'b1);
    step('0, MODE_RR, 0, 1'b1);

    chk("scoreboard_empty", 64'(q_d.size()), 64'd0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
